// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the serial fully-connected layer sequencer:
// state encoding and an address-width helper.
package fc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_MAC   = ST_MAC,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE
    } state_e;

    // Ceiling log2, never less than one bit so a single-entry memory still has an address port.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate register: either loads bias + product or adds
// the product onto the running sum. Accumulation wraps in two's complement.
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_bias,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic        [ACC_WIDTH-1:0]    acc_d;
    logic        [ACC_WIDTH-1:0]    acc_q;

    // Signed casts sign-extend (or truncate, for a narrow accumulator) to the accumulator width.
    assign prod     = $signed(op_a) * $signed(op_b);
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'($signed(bias));

    always_comb begin
        acc_d = acc_q;
        if (acc_en) begin
            acc_d = load_bias ? (bias_ext + prod_ext) : (acc_q + prod_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: walks bias/input/weight SRAMs through one
// shared MAC and writes one result per output neuron, then pulses finish.
module fc_seq_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int NUM_INPUTS  = 48,
    parameter int NUM_OUTPUTS = 10,
    parameter bit RELU_EN     = 1'b0,
    localparam int IW = clog2(NUM_INPUTS),
    localparam int WW = clog2(NUM_INPUTS * NUM_OUTPUTS),
    localparam int BW = clog2(NUM_OUTPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  finish,
    output logic [IW-1:0]         in_addr,
    input  logic [DATA_WIDTH-1:0] in_rdata,
    output logic [WW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic [BW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  out_we,
    output logic [BW-1:0]         out_addr,
    output logic [ACC_WIDTH-1:0]  out_data
);

    state_e          state_q, state_d;
    logic [BW-1:0]   o_q, o_d;
    logic [IW-1:0]   i_q, i_d;
    logic [WW-1:0]   wbase_q, wbase_d;
    logic [IW-1:0]   i_next;
    logic            i_last;
    logic            load_bias;
    logic            acc_en;
    logic [ACC_WIDTH-1:0] acc;

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load_bias(load_bias),
        .acc_en   (acc_en),
        .bias     (b_rdata),
        .op_a     (in_rdata),
        .op_b     (w_rdata),
        .acc      (acc)
    );

    // Prefetch index t+1 while accumulating index t; hold on the final input.
    assign i_last = (i_q == IW'(NUM_INPUTS - 1));
    assign i_next = i_last ? i_q : (i_q + 1'b1);

    always_comb begin
        state_d   = state_q;
        o_d       = o_q;
        i_d       = i_q;
        wbase_d   = wbase_q;
        busy      = (state_q != S_IDLE);
        finish    = 1'b0;
        in_addr   = '0;
        w_addr    = '0;
        b_addr    = '0;
        out_we    = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        load_bias = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    o_d     = '0;
                    i_d     = '0;
                    wbase_d = '0;
                end
            end
            S_LOAD: begin
                b_addr  = o_q;
                w_addr  = wbase_q;
                i_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                b_addr    = o_q;
                in_addr   = i_next;
                w_addr    = wbase_q + WW'(i_next);
                acc_en    = 1'b1;
                load_bias = (i_q == '0);
                if (i_last) begin
                    state_d = S_WRITE;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_WRITE: begin
                b_addr   = o_q;
                in_addr  = IW'(NUM_INPUTS - 1);
                w_addr   = wbase_q + WW'(NUM_INPUTS - 1);
                out_we   = 1'b1;
                out_addr = o_q;
                out_data = (RELU_EN && acc[ACC_WIDTH-1]) ? '0 : acc;
                if (o_q == BW'(NUM_OUTPUTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    o_d     = o_q + 1'b1;
                    wbase_d = wbase_q + WW'(NUM_INPUTS);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            i_q     <= '0;
            wbase_q <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            i_q     <= i_d;
            wbase_q <= wbase_d;
        end
    end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl: default, ReLU and 1x1/16-bit instances with
// behavioural SRAMs and a queue scoreboard of expected output writes.
module tb_fc_seq_ctrl;

    localparam int N = 48;
    localparam int M = 10;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, s_start;
    int   checks = 0;
    int   errors = 0;
    int   tnum   = 0;
    int   wr_a   = 0;
    int   fin_cnt = 0;
    bit   check_addr = 1'b0;
    logic [31:0] last_a, last_r;

    logic signed [7:0] in_mem [N];
    logic signed [7:0] w_mem  [N*M];
    logic signed [7:0] b_mem  [M];
    exp_t q_a[$];
    exp_t q_r[$];

    always #5 clk = ~clk;

    // Default instance (RELU off) and ReLU instance share stimulus and memory contents
    logic       a_busy, a_finish, a_we, r_busy, r_finish, r_we;
    logic [5:0] a_in_addr, r_in_addr;
    logic [8:0] a_w_addr, r_w_addr;
    logic [3:0] a_b_addr, r_b_addr, a_out_addr, r_out_addr;
    logic [31:0] a_out_data, r_out_data;
    logic [7:0] a_in_rd, a_w_rd, a_b_rd, r_in_rd, r_w_rd, r_b_rd;

    fc_seq_ctrl #(.RELU_EN(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy), .finish(a_finish),
        .in_addr(a_in_addr), .in_rdata(a_in_rd), .w_addr(a_w_addr), .w_rdata(a_w_rd),
        .b_addr(a_b_addr), .b_rdata(a_b_rd), .out_we(a_we), .out_addr(a_out_addr),
        .out_data(a_out_data));

    fc_seq_ctrl #(.RELU_EN(1'b1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .busy(r_busy), .finish(r_finish),
        .in_addr(r_in_addr), .in_rdata(r_in_rd), .w_addr(r_w_addr), .w_rdata(r_w_rd),
        .b_addr(r_b_addr), .b_rdata(r_b_rd), .out_we(r_we), .out_addr(r_out_addr),
        .out_data(r_out_data));

    // Single-neuron, single-input instance with a 16-bit accumulator
    logic       s_busy, s_finish, s_we;
    logic [0:0] s_in_addr, s_w_addr, s_b_addr, s_out_addr;
    logic [15:0] s_out_data;
    logic [7:0] s_in_rd, s_w_rd, s_b_rd;
    logic [7:0] s_in_v, s_w_v, s_b_v;
    int         s_writes = 0;
    logic [15:0] s_last;

    fc_seq_ctrl #(.ACC_WIDTH(16), .NUM_INPUTS(1), .NUM_OUTPUTS(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .finish(s_finish),
        .in_addr(s_in_addr), .in_rdata(s_in_rd), .w_addr(s_w_addr), .w_rdata(s_w_rd),
        .b_addr(s_b_addr), .b_rdata(s_b_rd), .out_we(s_we), .out_addr(s_out_addr),
        .out_data(s_out_data));

    always @(posedge clk) begin
        a_in_rd <= in_mem[a_in_addr];
        a_w_rd  <= w_mem[a_w_addr];
        a_b_rd  <= b_mem[a_b_addr];
        r_in_rd <= in_mem[r_in_addr];
        r_w_rd  <= w_mem[r_w_addr];
        r_b_rd  <= b_mem[r_b_addr];
        s_in_rd <= s_in_v;
        s_w_rd  <= s_w_v;
        s_b_rd  <= s_b_v;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input int o, input bit relu);
        int acc;
        acc = int'(b_mem[o]);
        for (int i = 0; i < N; i++) acc += int'(in_mem[i]) * int'(w_mem[o*N+i]);
        if (relu && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic push_run();
        for (int o = 0; o < M; o++) begin
            q_a.push_back('{addr: o, data: model(o, 1'b0)});
            q_r.push_back('{addr: o, data: model(o, 1'b1)});
        end
    endtask

    task automatic fill_const(input int iv, input int wv, input int bv);
        for (int i = 0; i < N; i++) in_mem[i] = 8'(iv);
        for (int k = 0; k < N*M; k++) w_mem[k] = 8'(wv);
        for (int o = 0; o < M; o++) b_mem[o] = 8'(bv);
    endtask

    // Ends at the negedge of cycle 1 (start sampled at the edge before it)
    task automatic launch();
        wr_a = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_finish(input int n0, input int expn, input string tag);
        int n;
        n = n0;
        while (!a_finish && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, expn);
    endtask

    always @(negedge clk) begin
        if (!rst && a_finish) fin_cnt++;
        if (!rst && a_we) begin
            wr_a++;
            last_a = a_out_data;
            if (q_a.size() == 0) chk("a_unexpected_write", 1, 0);
            else begin
                exp_t e;
                e = q_a.pop_front();
                $display("write a: addr=%0d data=%0d expected addr=%0d data=%0d",
                         a_out_addr, $signed(a_out_data), e.addr, $signed(e.data));
                chk("a_out_addr", a_out_addr, e.addr);
                chk("a_out_data", a_out_data, e.data);
            end
            if (tnum == 3 && a_out_addr == 4'd3) chk("t3_out3", a_out_data, 3381);
        end
        if (!rst && r_we) begin
            last_r = r_out_data;
            if (q_r.size() == 0) chk("r_unexpected_write", 1, 0);
            else begin
                exp_t e;
                e = q_r.pop_front();
                chk("r_out_addr", r_out_addr, e.addr);
                chk("r_out_data", r_out_data, e.data);
            end
        end
        if (check_addr && a_busy) chk("w_addr_map", a_w_addr, a_b_addr * N + a_in_addr);
        if (!rst && s_we) begin
            s_writes++;
            s_last = s_out_data;
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        s_in_v = 8'h80;
        s_w_v = 8'h80;
        s_b_v = 8'h00;
        fill_const(1, 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_finish", a_finish, 0);
        chk("rst_out", {a_we, a_out_addr, a_out_data}, 0);
        chk("rst_addr", {a_in_addr, a_w_addr, a_b_addr}, 0);
        rst = 1'b0;

        // 1: all ones
        tnum = 1;
        push_run();
        launch();
        chk("t1_busy_c1", a_busy, 1);
        wait_finish(1, 501, "t1_finish_cycle");
        chk("t1_busy_at_finish", a_busy, 1);
        @(negedge clk);
        chk("t1_busy_after", a_busy, 0);
        chk("t1_finish_pulse", a_finish, 0);
        chk("t1_writes", wr_a, 10);
        chk("t1_value", last_a, 49);
        chk("t1_queue_empty", q_a.size() + q_r.size(), 0);

        // 2: negative result, with and without ReLU
        tnum = 2;
        fill_const(1, -1, 1);
        push_run();
        launch();
        wait_finish(1, 501, "t2_finish_cycle");
        @(negedge clk);
        chk("t2_plain", last_a, 32'hFFFF_FFD1);
        chk("t2_relu", last_r, 0);

        // 3: ramp pattern and weight-address map
        tnum = 3;
        for (int i = 0; i < N; i++) in_mem[i] = 8'(i);
        for (int o = 0; o < M; o++) begin
            b_mem[o] = 8'(-o);
            for (int i = 0; i < N; i++) w_mem[o*N+i] = 8'(o);
        end
        push_run();
        check_addr = 1'b1;
        launch();
        wait_finish(1, 501, "t3_finish_cycle");
        @(negedge clk);
        check_addr = 1'b0;
        chk("t3_writes", wr_a, 10);

        // 4: start while busy and in DONE is ignored, start right after DONE runs again
        tnum = 4;
        fill_const(1, 1, 1);
        push_run();
        launch();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_finish(6, 501, "t4_finish_cycle");
        chk("t4_writes", wr_a, 10);
        push_run();
        start = 1'b1;
        @(negedge clk);
        chk("t4_idle_502", a_busy, 0);
        wr_a = 0;
        @(negedge clk) start = 1'b0;
        chk("t4_restart_busy", a_busy, 1);
        wait_finish(1, 501, "t4_rerun_finish_cycle");
        @(negedge clk);
        chk("t4_rerun_writes", wr_a, 10);

        // 5: reset mid-run
        tnum = 5;
        push_run();
        launch();
        repeat (119) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_out", {a_finish, a_we, a_out_addr, a_out_data}, 0);
        chk("t5_rst_addr", {a_in_addr, a_w_addr, a_b_addr}, 0);
        chk("t5_writes_before_rst", wr_a, 2);
        rst = 1'b0;
        q_a.delete();
        q_r.delete();
        fin_cnt = 0;
        repeat (600) @(negedge clk);
        chk("t5_no_finish", fin_cnt, 0);
        push_run();
        launch();
        wait_finish(1, 501, "t5_fresh_finish_cycle");
        @(negedge clk);
        chk("t5_fresh_writes", wr_a, 10);
        chk("t5_fresh_value", last_a, 49);

        // 6: N=1, M=1, 16-bit accumulator
        tnum = 6;
        begin
            int n;
            @(negedge clk) s_start = 1'b1;
            @(negedge clk) s_start = 1'b0;
            n = 1;
            while (!s_finish && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_finish_cycle", n, 4);
            @(negedge clk);
            chk("t6_writes", s_writes, 1);
            chk("t6_value", s_last, 16384);
            chk("t6_busy_after", s_busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
